// File: rtl/dice_roll_tracker.sv
// Dice roll statistics: captures the value when roll falls, tracks history and sums.
// Optional per-face histogram enabled with DICE_HISTOGRAM_EN.
module dice_roll_tracker #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               roll,
    input  logic [2:0]         dice_value,
    output logic [2:0]         last_value,
    output logic [2:0]         prev_value,
    output logic [COUNT_W-1:0] roll_count,
    output logic [COUNT_W+2:0] total_sum,
    output logic               capture_valid,
    output logic               double_flag,
    output logic               error_flag,
    input  logic [2:0]         face_sel,
    output logic [COUNT_W-1:0] face_count
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] ROLLING = 1'b1;

    logic [0:0] state;
    logic       capture;
    logic       legal;
    logic       sat;
    logic       counted;
    logic       is_double;

    assign capture   = (state == ROLLING) && !roll;
    assign legal     = (dice_value != 3'd0) && (dice_value != 3'd7);
    assign sat       = (roll_count == {COUNT_W{1'b1}});
    assign counted   = capture && legal && !sat;
    assign is_double = (roll_count != '0) && (dice_value == last_value);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_value    <= '0;
            prev_value    <= '0;
            roll_count    <= '0;
            total_sum     <= '0;
            capture_valid <= 1'b0;
            double_flag   <= 1'b0;
            error_flag    <= 1'b0;
        end else begin
            state         <= roll ? ROLLING : IDLE;
            capture_valid <= counted;
            double_flag   <= counted && is_double;
            if (capture && !legal)
                error_flag <= 1'b1;
            if (counted) begin
                prev_value <= last_value;
                last_value <= dice_value;
                roll_count <= roll_count + 1'b1;
                total_sum  <= total_sum + (COUNT_W+3)'(dice_value);
            end
        end
    end

`ifdef DICE_HISTOGRAM_EN
    // hist[i] counts face i+1
    logic [COUNT_W-1:0] hist [0:5];
    logic [2:0]         idx;

    assign idx = dice_value - 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++)
                hist[i] <= '0;
        end else if (counted) begin
            hist[idx] <= hist[idx] + 1'b1;
        end
    end

    always_comb begin
        face_count = '0;
        case (face_sel)
            3'd1: face_count = hist[0];
            3'd2: face_count = hist[1];
            3'd3: face_count = hist[2];
            3'd4: face_count = hist[3];
            3'd5: face_count = hist[4];
            3'd6: face_count = hist[5];
            default: face_count = '0;
        endcase
    end
`else
    logic unused_sel;

    assign unused_sel = ^face_sel;
    assign face_count = '0;
`endif

endmodule

// File: doc/dice_roll_tracker.md
DICE_ROLL_TRACKER -- requirements
Module: dice_roll_tracker

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8: width of the roll counter and of each face counter.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port roll, input, 1: roll request, the same signal that drives digital_dice_simulator.
REQ-005 The block SHALL have port dice_value, input, 3: dice value produced by digital_dice_simulator; legal range 1..6.
REQ-006 The block SHALL have port last_value, output, 3: most recent valid captured value.
REQ-007 The block SHALL have port prev_value, output, 3: valid value captured before last_value.
REQ-008 The block SHALL have port roll_count, output, COUNT_W: number of valid captures, saturating.
REQ-009 The block SHALL have port total_sum, output, COUNT_W+3: sum of all counted captures.
REQ-010 The block SHALL have port capture_valid, output, 1: one-cycle pulse marking a counted capture.
REQ-011 The block SHALL have port double_flag, output, 1: one-cycle pulse when a counted capture equals the previous last_value.
REQ-012 The block SHALL have port error_flag, output, 1: sticky flag for an illegal value at capture.
REQ-013 The block SHALL have port face_sel, input, 3: selects the face counter to read (1..6).
REQ-014 The block SHALL have port face_count, output, COUNT_W: count of the face selected by face_sel.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE (reset state) and ROLLING.
- IDLE->ROLLING when roll=1 is sampled.
- ROLLING->IDLE when roll=0 is sampled. This transition is the capture event.
- ROLLING holds while roll=1.
REQ-016 The block SHALL sample dice_value on the same clock edge as the capture event; results SHALL appear on the outputs in the following cycle, giving a latency of one clock after the edge that samples roll=0.
REQ-017 On a capture with dice_value in 1..6 and roll_count below 2^COUNT_W-1, the block SHALL update registers as follows:
- prev_value <= last_value
- last_value <= dice_value
- roll_count += 1
- total_sum += dice_value
- capture_valid = 1 for exactly one cycle
REQ-018 On a counted capture with roll_count>=1 and dice_value==last_value, double_flag SHALL pulse for one cycle, coincident with capture_valid.
REQ-019 The first counted capture after reset SHALL never assert double_flag.
REQ-020 On a capture with dice_value of 0 or 7, the block SHALL set error_flag and SHALL NOT change any other register; capture_valid and double_flag SHALL stay 0.
REQ-021 When roll_count equals 2^COUNT_W-1, further legal captures SHALL freeze all statistics (last_value, prev_value, roll_count, total_sum, face counters), and capture_valid SHALL stay 0.
REQ-022 total_sum SHALL be wide enough that it cannot overflow before roll_count saturates (6*(2^COUNT_W-1) < 2^(COUNT_W+3)).
REQ-023 In IDLE, a roll pulse lasting exactly one cycle SHALL produce exactly one capture.
REQ-024 Changes on dice_value while the FSM is in IDLE SHALL be ignored.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL return to IDLE and clear every output to 0:
- last_value=0, prev_value=0
- roll_count=0, total_sum=0
- capture_valid=0, double_flag=0, error_flag=0
- face counters=0
REQ-026 Reset SHALL take priority over a simultaneous capture event; a roll in progress when reset is asserted SHALL be discarded.
REQ-027 Reset SHALL be the only means of clearing error_flag.

Configuration
REQ-028 Macro DICE_HISTOGRAM_EN defined: the block SHALL keep six COUNT_W-bit face counters. Each counted capture SHALL increment the counter for its face. face_count SHALL combinationally return the counter selected by face_sel, and SHALL return 0 for face_sel 0 or 7.
REQ-029 Macro DICE_HISTOGRAM_EN undefined: the block SHALL contain no face counters, and face_count SHALL be tied to 0. Ports SHALL be unchanged.

Verification
REQ-030 Reset, then roll=1 for 2 cycles with dice_value=4, then roll=0 -> one cycle later: last_value=4, roll_count=1, total_sum=4, capture_valid=1, double_flag=0.
REQ-031 Two consecutive rolls, each captured with dice_value=6 -> second capture: capture_valid=1, double_flag=1, prev_value=6, total_sum=12.
REQ-032 Capture with dice_value=7 -> error_flag=1, roll_count unchanged, capture_valid=0; a later legal capture still counts while error_flag remains 1.
REQ-033 With COUNT_W=3, perform 8 legal captures of value 2 -> roll_count=7, total_sum=14, 8th capture_valid=0.
REQ-034 Assert reset in the cycle where roll falls -> all outputs 0 next cycle, no capture_valid.
REQ-035 With DICE_HISTOGRAM_EN, captures 1,3,3,5, then face_sel=3 -> face_count=2; face_sel=7 -> 0. Without the macro, face_count=0 throughout.
